// File: rtl/thread_dispatch_pkg.sv
// Shared types and defaults for the thread dispatcher: slot state encoding
// and the retire disposition record.
package thread_dispatch_pkg;

    localparam int NUM_CTX_DEFAULT = 8;
    localparam int SLEEP_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUEUED   = 2'd1,
        RUNNING  = 2'd2,
        SLEEPING = 2'd3
    } ctx_state_t;

    typedef struct packed {
        logic [$clog2(NUM_CTX_DEFAULT)-1:0] ctx;
        logic signed [SLEEP_W_DEFAULT-1:0]  sleep;
    } retire_t;

endpackage

// File: rtl/thread_dispatcher_rr_pick.sv
// Combinational round-robin finder: first set bit of req at or after ptr,
// wrapping modulo N (N a power of two).
module rr_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [N-1:0] rot;
    logic [W-1:0] off;

    // Rotate so bit 0 of rot is the slot at ptr; W-bit sum wraps for free.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            rot[i] = req[ptr + W'(i)];
        end
    end

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = W'(i);
        end
    end

    assign found = |rot;
    assign idx   = ptr + off;

endmodule

// File: rtl/thread_dispatcher.sv
// Thread context scheduler: load/issue/retire/sleep per slot, round-robin issue.
// Optional DISPATCH_STATS_EN adds saturating issue and stall counters.
module thread_dispatcher
    import thread_dispatch_pkg::*;
#(
    parameter int NUM_CTX = NUM_CTX_DEFAULT,
    parameter int CTX_W   = $clog2(NUM_CTX),
    parameter int SLEEP_W = SLEEP_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load_valid,
    input  logic [CTX_W-1:0]          load_ctx,
    output logic                      load_err,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [CTX_W-1:0]          issue_ctx,
    input  logic                      retire_valid,
    input  logic [CTX_W-1:0]          retire_ctx,
    input  logic signed [SLEEP_W-1:0] retire_sleep,
    output logic                      retire_err,
    output logic [NUM_CTX-1:0]        queued_mask,
    output logic [CTX_W:0]            idle_count
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]               stat_issued,
    output logic [31:0]               stat_stall
`endif
);

    localparam int CNT_W = CTX_W + 1;

    ctx_state_t         st_q  [NUM_CTX];
    ctx_state_t         st_d  [NUM_CTX];
    logic [SLEEP_W-1:0] cnt_q [NUM_CTX];
    logic [SLEEP_W-1:0] cnt_d [NUM_CTX];

    logic [CTX_W-1:0]   ptr_q, ptr_d;
    logic [CTX_W-1:0]   issue_ctx_q, issue_ctx_d;
    logic               issue_valid_q, issue_valid_d;
    logic               load_err_q, load_err_d;
    logic               retire_err_q, retire_err_d;
    logic [NUM_CTX-1:0] queued_mask_q, queued_mask_d;
    logic [CNT_W-1:0]   idle_count_q, idle_count_d;

    logic               hs;
    logic [NUM_CTX-1:0] pick_req;
    logic [CTX_W-1:0]   pick_ptr, pick_idx;
    logic               pick_found;

    assign hs = issue_valid_q & issue_ready;

    // The slot leaving on this handshake is still QUEUED pre-edge; mask it out.
    always_comb begin
        for (int i = 0; i < NUM_CTX; i++) begin
            pick_req[i] = (st_q[i] == QUEUED);
        end
        if (hs) pick_req[issue_ctx_q] = 1'b0;
    end

    assign pick_ptr = hs ? issue_ctx_q + CTX_W'(1) : ptr_q;

    rr_pick #(.N(NUM_CTX), .W(CTX_W)) u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Load, handshake, retire and countdown each require a distinct pre-edge
    // state, so they never compete for the same slot.
    always_comb begin
        st_d         = st_q;
        cnt_d        = cnt_q;
        load_err_d   = 1'b0;
        retire_err_d = 1'b0;

        for (int i = 0; i < NUM_CTX; i++) begin
            if (st_q[i] == SLEEPING) begin
                if (cnt_q[i] <= SLEEP_W'(1)) begin
                    st_d[i]  = QUEUED;
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] - SLEEP_W'(1);
                end
            end
        end

        if (load_valid) begin
            if (st_q[load_ctx] == IDLE) st_d[load_ctx] = QUEUED;
            else                        load_err_d = 1'b1;
        end

        if (hs) st_d[issue_ctx_q] = RUNNING;

        if (retire_valid) begin
            if (st_q[retire_ctx] == RUNNING) begin
                if (retire_sleep[SLEEP_W-1]) begin
                    st_d[retire_ctx] = IDLE;
                end else if (retire_sleep == '0) begin
                    st_d[retire_ctx] = QUEUED;
                end else begin
                    st_d[retire_ctx]  = SLEEPING;
                    cnt_d[retire_ctx] = $unsigned(retire_sleep);
                end
            end else begin
                retire_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d         = hs ? issue_ctx_q + CTX_W'(1) : ptr_q;
        issue_valid_d = issue_valid_q;
        issue_ctx_d   = issue_ctx_q;
        if (!issue_valid_q || issue_ready) begin
            issue_valid_d = pick_found;
            if (pick_found) issue_ctx_d = pick_idx;
        end
    end

    always_comb begin
        queued_mask_d = '0;
        idle_count_d  = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            queued_mask_d[i] = (st_d[i] == QUEUED);
            if (st_d[i] == IDLE) idle_count_d = idle_count_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                st_q[i]  <= IDLE;
                cnt_q[i] <= '0;
            end
            ptr_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_ctx_q   <= '0;
            load_err_q    <= 1'b0;
            retire_err_q  <= 1'b0;
            queued_mask_q <= '0;
            idle_count_q  <= CNT_W'(NUM_CTX);
        end else begin
            st_q          <= st_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            issue_valid_q <= issue_valid_d;
            issue_ctx_q   <= issue_ctx_d;
            load_err_q    <= load_err_d;
            retire_err_q  <= retire_err_d;
            queued_mask_q <= queued_mask_d;
            idle_count_q  <= idle_count_d;
        end
    end

    assign load_err    = load_err_q;
    assign retire_err  = retire_err_q;
    assign issue_valid = issue_valid_q;
    assign issue_ctx   = issue_ctx_q;
    assign queued_mask = queued_mask_q;
    assign idle_count  = idle_count_q;

`ifdef DISPATCH_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_stall_d  = stat_stall_q;
        if (hs && stat_issued_q != '1) stat_issued_d = stat_issued_q + 32'd1;
        if (issue_valid_q && !issue_ready && stat_stall_q != '1) stat_stall_d = stat_stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_thread_dispatcher.sv
// Randomized + directed bench for thread_dispatcher against a slot-level
// reference model; define DISPATCH_STATS_EN to also cover the stat counters.
module tb_thread_dispatcher;

    localparam int NUM = 8;
    localparam int M_IDLE = 0, M_QUEUED = 1, M_RUNNING = 2, M_SLEEPING = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [2:0]  load_ctx = '0;
    logic        load_err;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [2:0]  issue_ctx;
    logic        retire_valid = 1'b0;
    logic [2:0]  retire_ctx = '0;
    logic signed [15:0] retire_sleep = '0;
    logic        retire_err;
    logic [7:0]  queued_mask;
    logic [3:0]  idle_count;
`ifdef DISPATCH_STATS_EN
    logic [31:0] stat_issued, stat_stall;
`endif

    thread_dispatcher dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_valid   (load_valid),
        .load_ctx     (load_ctx),
        .load_err     (load_err),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_ctx    (issue_ctx),
        .retire_valid (retire_valid),
        .retire_ctx   (retire_ctx),
        .retire_sleep (retire_sleep),
        .retire_err   (retire_err),
        .queued_mask  (queued_mask),
        .idle_count   (idle_count)
`ifdef DISPATCH_STATS_EN
        ,
        .stat_issued  (stat_issued),
        .stat_stall   (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: slot states, remaining sleep, current offer, pointer.
    int  mst [NUM];
    int  mcnt[NUM];
    bit  miv;
    int  mic;
    int  mptr;
    bit  mlerr, mrerr;
    longint missued, mstall;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM; i++) begin
            mst[i] = M_IDLE;
            mcnt[i] = 0;
        end
        miv = 0; mic = 0; mptr = 0; mlerr = 0; mrerr = 0;
        missued = 0; mstall = 0;
    endfunction

    function automatic void model_edge(bit lv, int lc, bit ir, bit rv, int rc, int rs);
        int  pre[NUM];
        bit  hs;
        int  start;
        bit  got;
        pre = mst;
        hs = miv && ir;
        mlerr = 0;
        mrerr = 0;
        if (hs) missued++;
        if (miv && !ir) mstall++;
        for (int i = 0; i < NUM; i++) begin
            if (pre[i] == M_SLEEPING) begin
                mcnt[i]--;
                if (mcnt[i] == 0) mst[i] = M_QUEUED;
            end
        end
        if (lv) begin
            if (pre[lc] == M_IDLE) mst[lc] = M_QUEUED;
            else mlerr = 1;
        end
        if (hs) mst[mic] = M_RUNNING;
        if (rv) begin
            if (pre[rc] == M_RUNNING) begin
                if (rs < 0) mst[rc] = M_IDLE;
                else if (rs == 0) mst[rc] = M_QUEUED;
                else begin
                    mst[rc] = M_SLEEPING;
                    mcnt[rc] = rs;
                end
            end else mrerr = 1;
        end
        if (!miv || ir) begin
            start = hs ? (mic + 1) % NUM : mptr;
            got = 0;
            for (int k = 0; k < NUM; k++) begin
                int j;
                j = (start + k) % NUM;
                if (!got && pre[j] == M_QUEUED && !(hs && j == mic)) begin
                    got = 1;
                    if (hs) mptr = (mic + 1) % NUM;
                    mic = j;
                end
            end
            if (!got && hs) mptr = (mic + 1) % NUM;
            miv = got;
        end
    endfunction

    function automatic int m_qmask();
        int m = 0;
        for (int i = 0; i < NUM; i++) if (mst[i] == M_QUEUED) m |= (1 << i);
        return m;
    endfunction

    function automatic int m_idle();
        int n = 0;
        for (int i = 0; i < NUM; i++) if (mst[i] == M_IDLE) n++;
        return n;
    endfunction

    task automatic compare_all();
        chk("issue_valid", 64'(issue_valid), 64'(miv));
        chk("issue_ctx", 64'(issue_ctx), 64'(mic));
        chk("load_err", 64'(load_err), 64'(mlerr));
        chk("retire_err", 64'(retire_err), 64'(mrerr));
        chk("queued_mask", 64'(queued_mask), 64'(m_qmask()));
        chk("idle_count", 64'(idle_count), 64'(m_idle()));
`ifdef DISPATCH_STATS_EN
        chk("stat_issued", 64'(stat_issued), 64'(missued));
        chk("stat_stall", 64'(stat_stall), 64'(mstall));
`endif
    endtask

    task automatic cyc(input bit lv, input int lc, input bit ir, input bit rv, input int rc, input int rs);
        load_valid   = lv;
        load_ctx     = 3'(lc);
        issue_ready  = ir;
        retire_valid = rv;
        retire_ctx   = 3'(rc);
        retire_sleep = 16'(rs);
        @(posedge clk);
        model_edge(lv, lc, ir, rv, rc, rs);
        #1;
        compare_all();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_valid"}, 64'(issue_valid), 64'd0);
        chk({tag, "_ctx"}, 64'(issue_ctx), 64'd0);
        chk({tag, "_lerr"}, 64'(load_err), 64'd0);
        chk({tag, "_rerr"}, 64'(retire_err), 64'd0);
        chk({tag, "_qmask"}, 64'(queued_mask), 64'd0);
        chk({tag, "_idle"}, 64'(idle_count), 64'd8);
`ifdef DISPATCH_STATS_EN
        chk({tag, "_sissued"}, 64'(stat_issued), 64'd0);
        chk({tag, "_sstall"}, 64'(stat_stall), 64'd0);
`endif
    endtask

    initial begin
        longint s0, i0;
        int idle0;
        thread_dispatch_pkg::retire_t rt;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // Single load: offered one edge after the load edge, then running.
        cyc(1, 3, 1, 0, 0, 0);
        chk("t1_not_yet", 64'(issue_valid), 64'd0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("t1_valid", 64'(issue_valid), 64'd1);
        chk("t1_ctx", 64'(issue_ctx), 64'd3);
        cyc(0, 0, 1, 0, 0, 0);
        chk("t1_idle7", 64'(idle_count), 64'd7);

        // Back-to-back issue of 0,1,5.
        cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        chk("t2_ctx0", 64'(issue_ctx), 64'd0);
        cyc(1, 5, 1, 0, 0, 0);
        chk("t2_ctx1", 64'(issue_ctx), 64'd1);
        cyc(0, 0, 1, 0, 0, 0);
        chk("t2_ctx5", 64'(issue_ctx), 64'd5);
        cyc(0, 0, 1, 0, 0, 0);
        chk("t2_drained", 64'(issue_valid), 64'd0);

        // Back-pressure on ctx 2.
`ifdef DISPATCH_STATS_EN
        s0 = longint'(stat_stall);
        i0 = longint'(stat_issued);
`else
        s0 = 0; i0 = 0;
`endif
        cyc(1, 2, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("t3_hold_valid", 64'(issue_valid), 64'd1);
            chk("t3_hold_ctx", 64'(issue_ctx), 64'd2);
        end
        cyc(0, 0, 1, 0, 0, 0);
        chk("t3_done", 64'(issue_valid), 64'd0);
`ifdef DISPATCH_STATS_EN
        chk("t3_stall4", 64'(longint'(stat_stall) - s0), 64'd4);
        chk("t3_issued1", 64'(longint'(stat_issued) - i0), 64'd1);
`endif

        // Sleep 100: queued exactly 100 edges after the retire edge.
        cyc(0, 0, 1, 1, 2, 100);
        for (int k = 1; k <= 100; k++) begin
            cyc(0, 0, 1, 0, 0, 0);
            if (k == 99) chk("t4_sleep99", 64'(queued_mask[2]), 64'd0);
            if (k == 100) chk("t4_wake100", 64'(queued_mask[2]), 64'd1);
        end
        cyc(0, 0, 1, 0, 0, 0);
        chk("t4_reoffer", 64'(issue_ctx), 64'd2);
        cyc(0, 0, 1, 0, 0, 0);
        // Load to running slot 2 is rejected.
        cyc(1, 2, 1, 0, 0, 0);
        chk("t5_lerr", 64'(load_err), 64'd1);
        chk("t5_nochg", 64'(queued_mask[2]), 64'd0);
        idle0 = int'(idle_count);
        cyc(0, 0, 1, 1, 2, -100);
        chk("t4_free", 64'(idle_count), 64'(idle0 + 1));

        // Retire of a queued (offered) slot is rejected.
        cyc(1, 4, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 4, 0);
        chk("t5_rerr", 64'(retire_err), 64'd1);
        chk("t5_still_q", 64'(queued_mask[4]), 64'd1);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);

        // Several slots sleeping, then async reset mid-handshake.
        cyc(0, 0, 1, 1, 0, 50);
        cyc(0, 0, 1, 1, 1, 50);
        cyc(1, 6, 0, 1, 3, 50);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t6_offer6", 64'(issue_ctx), 64'd6);
        issue_ready = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        reset_checks("arst");
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1, 7, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("t6_post_ctx", 64'(issue_ctx), 64'd7);
        chk("t6_post_valid", 64'(issue_valid), 64'd1);
        cyc(0, 0, 1, 0, 0, 0);

        // Maximum positive sleep counts the full range without wrapping.
        rt.ctx = 3'd7;
        rt.sleep = 16'sd32767;
        cyc(0, 0, 0, 1, int'(rt.ctx), int'(rt.sleep));
        for (int k = 1; k <= 32767; k++) begin
            cyc(0, 0, 0, 0, 0, 0);
            if (k == 32766) chk("max_sleep_hold", 64'(queued_mask[7]), 64'd0);
            if (k == 32767) chk("max_sleep_wake", 64'(queued_mask[7]), 64'd1);
        end

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            bit lv, ir, rv;
            int lc, rc, rs;
            int run[$];
            lv = ($urandom_range(0, 99) < 40);
            lc = int'($urandom_range(0, NUM - 1));
            ir = ($urandom_range(0, 99) < 65);
            rv = ($urandom_range(0, 99) < 45);
            run.delete();
            for (int i = 0; i < NUM; i++) if (mst[i] == M_RUNNING) run.push_back(i);
            if (run.size() > 0 && $urandom_range(0, 9) < 8)
                rc = run[$urandom_range(0, run.size() - 1)];
            else
                rc = int'($urandom_range(0, NUM - 1));
            case ($urandom_range(0, 3))
                0: rs = -int'($urandom_range(1, 32768));
                1: rs = 0;
                default: rs = int'($urandom_range(1, 12));
            endcase
            cyc(lv, lc, ir, rv, rc, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
